idwt_haar_non_pipelined_top: RTL and testbench
==============================================

Name: idwt_haar_non_pipelined_top

Overview:
- Inverse single-level Haar DWT, the synthesis side matching the forward non-pipelined Haar DWT block.
- Takes N/2 approximation (cA) and N/2 detail (cD) coefficients and reconstructs N 16-bit samples, one pair at a time through a single shared butterfly.
- The butterfly is a sum/difference followed by multiply-by-181 and scaling by 1/256 (181/256 ≈ 1/√2).
- The block has a controller FSM and a datapath, and uses a start/done handshake.

Parameters:
- N, 8, number of reconstructed samples; a power of 2 with N ≥ 4; the pair count is N/2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to run; sampled only in IDLE.
- cA_in  input  16*(N/2)  approximation coefficients, 16-bit two's complement; coefficient k is at [16k +: 16].
- cD_in  input  16*(N/2)  detail coefficients, same packing as cA_in.
- array_out  output  16*N  reconstructed samples; sample j is at [16j +: 16].
- busy  output  1  high in states LOAD, PROCESS and STORE.
- done  output  1  high while the FSM is in DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; pair_idx goes to 0.
  - Shadow registers, operand registers and result registers clear to 0.
  - array_out = 0, busy = 0, done = 0.
  - A reset mid-run aborts the run immediately; no partial results are preserved.
- Capture: at the clock edge where state = IDLE and start = 1, cA_in and cD_in are copied into internal shadow registers. The inputs may change freely after that edge.
- FSM states: IDLE, LOAD, PROCESS, STORE, DONE (binary encoded).
  - IDLE → LOAD when start = 1; otherwise stay in IDLE.
  - LOAD → PROCESS. Operand registers a ← shadow cA[pair_idx], b ← shadow cD[pair_idx].
  - PROCESS → STORE. Result registers y0, y1 ← butterfly(a, b).
  - STORE → LOAD if pair_idx < N/2-1; → DONE if pair_idx = N/2-1.
    - At this edge: array_out[32·pair_idx +: 16] ← y0 and array_out[32·pair_idx+16 +: 16] ← y1.
    - pair_idx increments when the next state is LOAD.
  - DONE → IDLE when start = 0; stay in DONE while start = 1 (no auto-restart, level handshake).
- Butterfly arithmetic (all signed):
  - s = sext17(a) + sext17(b); d = sext17(a) − sext17(b).
  - ps = s·181 and pd = d·181, computed at 26 bits or wider.
  - y0 = ps[23:8] and y1 = pd[23:8]. This is an arithmetic shift right by 8 (floor), then wrap to 16 bits with no saturation.
  - ×181 is implemented as shift-add (128+32+16+4+1), with no generic multiplier.
- Latency:
  - 3 cycles per pair.
  - With the start edge at t0, the final pair is written and done rises at edge t0 + 3·(N/2). For N = 8 that is 12 cycles.
  - busy rises at t0 and falls at the same edge where done rises.
- Start behaviour:
  - start is ignored in LOAD, PROCESS and STORE; the shadow registers are not recaptured.
  - start held high through a run does not retrigger, because DONE waits for start = 0.
- Output hold:
  - array_out holds the previous result until it is overwritten pair by pair by the next run.
  - array_out is not cleared on a new start.

Optional Feature:
- Macro: IDWT_HAAR_ROUND_EN.
- Defined: y0 = (ps + 128)[23:8] and y1 = (pd + 128)[23:8], i.e. round-half-up instead of floor. The adder for +128 sits in the PROCESS stage and latency is unchanged.
- Undefined: floor truncation exactly as in Behaviour.

Test Plan:
- N = 8, all cA = 0x0100, all cD = 0 → every sample is 0x00B5 (181). done rises exactly 12 cycles after the start edge; busy is high for those 12 cycles.
- Pair 0 with cA = 100, cD = 20 → array_out[15:0] = 84 and [31:16] = 56. With IDWT_HAAR_ROUND_EN defined: 85 and 57.
- Negative path: cA = 0, cD = 0x0100 → x0 = 0x00B5, x1 = 0xFF4B (−181). cA = 0xFFFF, cD = 0 → both samples 0xFFFF.
- Wrap: cA = cD = 0x7FFF → x0 = 0xB4FE (no saturation), x1 = 0x0000.
- Handshake:
  - Change cA_in/cD_in one cycle after start → output reflects the originally captured values.
  - Hold start high → the block stays in DONE with done = 1. Drop start → IDLE on the next edge with done = 0.
  - A second start pulse while busy → no effect.
- Reset mid-run: drive rst_n low during the PROCESS state of pair 2 → asynchronously array_out = 0, busy = 0, done = 0. After release, a new start completes normally in 12 cycles.

Source files
------------

// File: rtl/idwt_haar_non_pipelined_top_if.sv
// Handshake and coefficient/sample bus for the inverse Haar DWT block.
// Parameter N sets the reconstructed sample count.
interface idwt_haar_non_pipelined_top_if #(
  parameter int N = 8
) ();
  logic              start;
  logic [8*N-1:0]    cA_in;
  logic [8*N-1:0]    cD_in;
  logic [16*N-1:0]   array_out;
  logic              busy;
  logic              done;

  modport master (
    output start,
    output cA_in,
    output cD_in,
    input  array_out,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  cA_in,
    input  cD_in,
    output array_out,
    output busy,
    output done
  );
endinterface

// File: rtl/idwt_haar_non_pipelined_top.sv
// Inverse single-level Haar DWT, one pair per 3 cycles via a shared butterfly.
// Define IDWT_HAAR_ROUND_EN for round-half-up instead of floor scaling.
module idwt_haar_non_pipelined_top #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst_n,
  idwt_haar_non_pipelined_top_if.slave bus
);
  localparam int P  = N / 2;
  localparam int IW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PROCESS,
    STORE,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [IW-1:0]      pair_idx;
  logic [16*P-1:0]    sh_a;
  logic [16*P-1:0]    sh_d;
  logic [15:0]        a;
  logic [15:0]        b;
  logic [15:0]        y0;
  logic [15:0]        y1;
  logic [16*N-1:0]    arr;
  logic signed [16:0] s;
  logic signed [16:0] d;
  logic signed [25:0] ps;
  logic signed [25:0] pd;
  logic signed [25:0] ps_r;
  logic signed [25:0] pd_r;
  logic               last;
  logic               unused;

  // x*181 as shift-add: 128+32+16+4+1
  function automatic logic signed [25:0] mul181(
    input logic signed [16:0] v
  );
    logic signed [25:0] x;
    x = {{9{v[16]}}, v};
    return (x <<< 7) + (x <<< 5) + (x <<< 4)
         + (x <<< 2) + x;
  endfunction

  always_comb begin
    s  = {a[15], a} + {b[15], b};
    d  = {a[15], a} - {b[15], b};
    ps = mul181(s);
    pd = mul181(d);
`ifdef IDWT_HAAR_ROUND_EN
    ps_r = ps + 26'sd128;
    pd_r = pd + 26'sd128;
`else
    ps_r = ps;
    pd_r = pd;
`endif
  end

  assign unused = ^{ps_r[25:24], ps_r[7:0],
                    pd_r[25:24], pd_r[7:0]};

  assign last = (pair_idx == IW'(P - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = LOAD;
      LOAD:    state_nx = PROCESS;
      PROCESS: state_nx = STORE;
      STORE:   state_nx = last ? DONE : LOAD;
      DONE:    if (!bus.start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_idx <= '0;
      sh_a     <= '0;
      sh_d     <= '0;
      a        <= '0;
      b        <= '0;
      y0       <= '0;
      y1       <= '0;
      arr      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sh_a <= bus.cA_in;
            sh_d <= bus.cD_in;
          end
        end
        LOAD: begin
          a <= sh_a[16*pair_idx +: 16];
          b <= sh_d[16*pair_idx +: 16];
        end
        PROCESS: begin
          y0 <= ps_r[23:8];
          y1 <= pd_r[23:8];
        end
        STORE: begin
          arr[32*pair_idx +: 16]      <= y0;
          arr[32*pair_idx + 16 +: 16] <= y1;
          // rewind so the next run starts at pair 0
          if (last) pair_idx <= '0;
          else      pair_idx <= pair_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.array_out = arr;
  assign bus.busy = (state == LOAD) ||
                    (state == PROCESS) ||
                    (state == STORE);
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_idwt_haar_non_pipelined_top.sv
// Directed bench for idwt_haar_non_pipelined_top, N = 8.
// Expected samples are hand-computed constants.
module tb_idwt_haar_non_pipelined_top;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  idwt_haar_non_pipelined_top_if #(.N(8)) bus ();

  idwt_haar_non_pipelined_top #(.N(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pack4(
    input logic [15:0] v0, v1, v2, v3
  );
    return {v3, v2, v1, v0};
  endfunction

  function automatic logic [127:0] pack8(
    input logic [15:0] v0, v1, v2, v3,
    input logic [15:0] v4, v5, v6, v7
  );
    return {v7, v6, v5, v4, v3, v2, v1, v0};
  endfunction

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic run(input logic [63:0] ca,
                     input logic [63:0] cd,
                     input bit hold,
                     input bit poke,
                     output int lat,
                     output int busy_n,
                     output logic [127:0] snap);
    bus.cA_in = ca;
    bus.cD_in = cd;
    bus.start = 1'b1;
    @(posedge clk); #1;
    snap   = bus.array_out;
    lat    = 0;
    busy_n = 0;
    if (!hold) bus.start = 1'b0;
    if (poke) begin
      bus.cA_in = ~ca;
      bus.cD_in = ~cd ^ 64'h1234_5678_9abc_def0;
    end
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_n++;
      if (poke && lat == 4) bus.start = 1'b1;
      if (poke && lat == 5 && !hold) bus.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  logic [63:0]  ca1, cd1, ca2, cd2, ca3, cd3;
  logic [127:0] exp1, exp2, exp3, snap;
  int           lat, busy_n;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    ca1 = pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    cd1 = '0;
    exp1 = pack8(16'h00B5, 16'h00B5, 16'h00B5, 16'h00B5,
                 16'h00B5, 16'h00B5, 16'h00B5, 16'h00B5);
    ca2 = pack4(16'd100, 16'h0000, 16'hFFFF, 16'h7FFF);
    cd2 = pack4(16'd20,  16'h0100, 16'h0000, 16'h7FFF);
`ifdef IDWT_HAAR_ROUND_EN
    exp2 = pack8(16'd85, 16'd57, 16'h00B5, 16'hFF4B,
                 16'hFFFF, 16'hFFFF, 16'hB4FF, 16'h0000);
`else
    exp2 = pack8(16'd84, 16'd56, 16'h00B5, 16'hFF4B,
                 16'hFFFF, 16'hFFFF, 16'hB4FE, 16'h0000);
`endif
    ca3 = pack4(16'h0200, 16'h0200, 16'h0200, 16'h0200);
    cd3 = '0;
    exp3 = pack8(16'h016A, 16'h016A, 16'h016A, 16'h016A,
                 16'h016A, 16'h016A, 16'h016A, 16'h016A);

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.cA_in = '0;
    bus.cD_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_array", bus.array_out, '0);
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_done", 128'(bus.done), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // run 1: all-0x0100 approximation, inputs changed after capture
    run(ca1, cd1, 1'b0, 1'b1, lat, busy_n, snap);
    chk("r1_latency", 128'(lat), 128'(12));
    chk("r1_busy_cycles", 128'(busy_n), 128'(12));
    chk("r1_busy_at_done", 128'(bus.busy), 128'(0));
    chk("r1_array", bus.array_out, exp1);
    @(posedge clk); #1;
    chk("r1_idle_done", 128'(bus.done), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("r1_hold", bus.array_out, exp1);

    // run 2: mixed signs and wrap, start held high
    run(ca2, cd2, 1'b1, 1'b0, lat, busy_n, snap);
    chk("r2_no_clear", snap, exp1);
    chk("r2_latency", 128'(lat), 128'(12));
    chk("r2_array", bus.array_out, exp2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("r2_done_held", 128'(bus.done), 128'(1));
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("r2_drop_done", 128'(bus.done), 128'(0));
    chk("r2_drop_busy", 128'(bus.busy), 128'(0));

    // run 3: extra start pulse mid-run must be ignored
    run(ca3, cd3, 1'b0, 1'b1, lat, busy_n, snap);
    chk("r3_latency", 128'(lat), 128'(12));
    chk("r3_array", bus.array_out, exp3);
    @(posedge clk); #1;

    // run 4: reset during PROCESS of pair 2
    bus.cA_in = ca1;
    bus.cD_in = cd1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_array", bus.array_out, '0);
    chk("mid_rst_busy", 128'(bus.busy), 128'(0));
    chk("mid_rst_done", 128'(bus.done), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(ca2, cd2, 1'b0, 1'b0, lat, busy_n, snap);
    chk("r5_snap_zero", snap, '0);
    chk("r5_latency", 128'(lat), 128'(12));
    chk("r5_array", bus.array_out, exp2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
